// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and the matching transmitter.
//   - uart_state_t : frame FSM states
//   - PARITY_*     : parity mode constants for the PARITY parameter
//   - calc_cycle / calc_half : clocks per bit and half-bit point
//   - majority3    : 2-of-3 vote used to filter line noise
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Clocks per bit; clk_fre is in MHz, baud_rate in bits per second.
    function automatic int calc_cycle(input int clk_fre, input int baud_rate);
        return (clk_fre * 1_000_000) / baud_rate;
    endfunction

    function automatic int calc_half(input int cycle);
        return cycle / 2;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous FIFO buffering received frames.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   wr_en, wr_data  : write request and entry
//   rd_en           : pop the head entry (ignored while empty)
//   rd_data         : head entry, forced to 0 while empty
//   empty, full     : occupancy flags
//   overrun         : one-cycle pulse after a write was dropped because the FIFO was full
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             overrun
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty can be told apart.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_rd;
    logic             do_wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A read in the same cycle frees a slot, so a write to a full FIFO still succeeds.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= wr_en && full && !do_rd;
            if (do_wr) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: it is only visible through rd_data when non-empty.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver with a small receive FIFO.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   rx_pin         : asynchronous serial input, idle high
//   rx_data        : head-of-FIFO data (LSB received first)
//   rx_frame_err   : head entry had its stop bit sampled low
//   rx_parity_err  : head entry failed the parity check (always 0 without parity)
//   rx_data_valid  : FIFO holds at least one entry
//   rx_data_ready  : consumer takes the head entry when high together with valid
//   rx_overrun     : one-cycle pulse when a frame is dropped on a full FIFO
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FRE    = 27,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_data_valid,
    input  logic                 rx_data_ready,
    output logic                 rx_overrun
);

    localparam int CYCLE  = calc_cycle(CLK_FRE, BAUD_RATE);
    localparam int HALF   = calc_half(CYCLE);
    localparam int CNT_W  = $clog2(CYCLE) + 1;
    localparam int FIFO_W = DATA_BITS + 2;

    localparam logic [CNT_W-1:0] CNT_HALF_M2 = CNT_W'(HALF - 2);
    localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_HALF    = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CYCLE - 1);
    localparam logic [2:0]       LAST_BIT    = 3'(DATA_BITS - 1);

    logic                 sync_meta;
    logic                 sync_q;
    logic                 sync_prev;
    logic                 fall;

    uart_state_t          state;
    uart_state_t          state_next;
    logic [CNT_W-1:0]     cycle_cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [2:0]           bit_cnt;
    logic [2:0]           bit_next;
    logic [DATA_BITS-1:0] shift_data;
    logic [DATA_BITS-1:0] data_next;
    logic                 samp_a;
    logic                 samp_b;
    logic                 a_next;
    logic                 b_next;
    logic                 par_bit;
    logic                 par_next;
    logic                 bit_val;
    logic                 parity_err_calc;
    logic                 fifo_wr;
    logic [FIFO_W-1:0]    wr_word;
    logic [FIFO_W-1:0]    head_word;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_rd;

    // Two-flop synchronizer, plus a third flop holding the previous synchronized
    // value for falling-edge detection. Resetting to 1 matches an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_q    <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_meta <= rx_pin;
            sync_q    <= sync_meta;
            sync_prev <= sync_q;
        end
    end

    assign fall = sync_prev && !sync_q;

    // Samples at HALF-2 and HALF-1 are held; the vote completes with the HALF sample.
    assign bit_val = majority3(samp_a, samp_b, sync_q);

    always_comb begin
        parity_err_calc = 1'b0;
        if (PARITY != PARITY_NONE) begin
            parity_err_calc = ((^shift_data) ^ par_bit) != (PARITY == PARITY_ODD);
        end
    end

    assign wr_word = {shift_data, ~bit_val, parity_err_calc};

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cycle_cnt  <= '0;
            bit_cnt    <= '0;
            shift_data <= '0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            par_bit    <= 1'b0;
        end else begin
            state      <= state_next;
            cycle_cnt  <= cnt_next;
            bit_cnt    <= bit_next;
            shift_data <= data_next;
            samp_a     <= a_next;
            samp_b     <= b_next;
            par_bit    <= par_next;
        end
    end

    // Next-state logic. The stop bit is written at mid-bit and the FSM returns
    // to idle right away, so a following start edge is never missed.
    always_comb begin
        state_next = state;
        cnt_next   = cycle_cnt + CNT_W'(1);
        bit_next   = bit_cnt;
        data_next  = shift_data;
        a_next     = samp_a;
        b_next     = samp_b;
        par_next   = par_bit;
        fifo_wr    = 1'b0;

        if (cycle_cnt == CNT_HALF_M2) begin
            a_next = sync_q;
        end
        if (cycle_cnt == CNT_HALF_M1) begin
            b_next = sync_q;
        end

        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (fall) begin
                    state_next = S_START;
                    bit_next   = '0;
                end
            end
            S_START: begin
                if (cycle_cnt == CNT_HALF_M1 && sync_q) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else if (cycle_cnt == CNT_LAST) begin
                    state_next = S_DATA;
                    cnt_next   = '0;
                    bit_next   = '0;
                end
            end
            S_DATA: begin
                if (cycle_cnt == CNT_HALF) begin
                    data_next[bit_cnt] = bit_val;
                end
                if (cycle_cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (bit_cnt == LAST_BIT) begin
                        bit_next   = '0;
                        state_next = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (cycle_cnt == CNT_HALF) begin
                    par_next = bit_val;
                end
                if (cycle_cnt == CNT_LAST) begin
                    state_next = S_STOP;
                    cnt_next   = '0;
                end
            end
            S_STOP: begin
                if (cycle_cnt == CNT_HALF) begin
                    fifo_wr    = 1'b1;
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign fifo_rd = rx_data_valid && rx_data_ready;

    uart_rx_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (wr_word),
        .rd_en   (fifo_rd),
        .rd_data (head_word),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .overrun (rx_overrun)
    );

    assign rx_data_valid = !fifo_empty;
    assign {rx_data, rx_frame_err, rx_parity_err} = head_word;

    // Full is only observed inside the FIFO; keep it for debug visibility.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: self-checking bench for uart_rx_param.
// dut8 runs 8N1 with a scoreboard monitor; dut7 runs 7 data bits with even parity.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int CLK_MHZ = 1;
    localparam int BAUD    = 62500;
    localparam int CYC     = (CLK_MHZ * 1_000_000) / BAUD;
    localparam int HALF_T  = CYC / 2;

    logic       clk;
    logic       rst_n;
    logic       rx_pin8;
    logic [7:0] rx_data8;
    logic       rx_frame_err8;
    logic       rx_parity_err8;
    logic       rx_data_valid8;
    logic       rx_data_ready8;
    logic       rx_overrun8;

    logic       rx_pin7;
    logic [6:0] rx_data7;
    logic       rx_frame_err7;
    logic       rx_parity_err7;
    logic       rx_data_valid7;
    logic       rx_data_ready7;
    logic       rx_overrun7;

    int compared   = 0;
    int mismatched = 0;
    int ovr_count  = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    typedef struct {
        logic [7:0] data;
        bit         stop_val;
        int         glitch_bit;
        int         idle_bits;
        bit         exp_fe;
    } vec_t;

    vec_t vecs[8];

    uart_rx_param #(
        .CLK_FRE(CLK_MHZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .rx_pin(rx_pin8), .rx_data(rx_data8),
        .rx_frame_err(rx_frame_err8), .rx_parity_err(rx_parity_err8),
        .rx_data_valid(rx_data_valid8), .rx_data_ready(rx_data_ready8),
        .rx_overrun(rx_overrun8)
    );

    uart_rx_param #(
        .CLK_FRE(CLK_MHZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2), .FIFO_DEPTH(4)
    ) dut7 (
        .clk(clk), .rst_n(rst_n), .rx_pin(rx_pin7), .rx_data(rx_data7),
        .rx_frame_err(rx_frame_err7), .rx_parity_err(rx_parity_err7),
        .rx_data_valid(rx_data_valid7), .rx_data_ready(rx_data_ready7),
        .rx_overrun(rx_overrun7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every accepted head entry on dut8 must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rx_data_valid8 && rx_data_ready8) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_frame: got data 0x%0h, expected no frame", rx_data8);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("sb_data", int'(rx_data8), int'(mon_e.data));
                checkOutput("sb_frame_err", int'(rx_frame_err8), int'(mon_e.fe));
                checkOutput("sb_parity_err", int'(rx_parity_err8), int'(mon_e.pe));
            end
        end
        if (rx_overrun8) begin
            ovr_count++;
        end
    end

    task automatic set_pin(input bit sel7, input logic v);
        if (sel7) rx_pin7 = v;
        else      rx_pin8 = v;
    endtask

    task automatic drive_bit(input bit sel7, input logic v);
        set_pin(sel7, v);
        repeat (CYC) @(posedge clk);
        #1;
    endtask

    // Serialise one frame LSB first; glitch_bit >= 0 inverts that bit for one clock near mid-bit.
    task automatic applyStimulus(input bit sel7, input logic [7:0] data, input int nbits,
                                 input bit use_par, input bit par_val, input bit stop_val,
                                 input int glitch_bit, input int idle_bits);
        drive_bit(sel7, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            if (i == glitch_bit) begin
                set_pin(sel7, data[i]);
                repeat (HALF_T) @(posedge clk);
                #1 set_pin(sel7, ~data[i]);
                @(posedge clk);
                #1 set_pin(sel7, data[i]);
                repeat (CYC - HALF_T - 1) @(posedge clk);
                #1;
            end else begin
                drive_bit(sel7, data[i]);
            end
        end
        if (use_par) drive_bit(sel7, par_val);
        drive_bit(sel7, stop_val);
        for (int i = 0; i < idle_bits; i++) drive_bit(sel7, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput(name, sb_q.size(), 0);
    endtask

    task automatic wait_valid7(input string name);
        int n;
        n = 0;
        while (!rx_data_valid7 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput(name, int'(rx_data_valid7), 1);
    endtask

    initial begin
        logic [6:0] d7;
        logic       good_par;

        vecs[0] = '{8'h55, 1'b1, -1, 0, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, -1, 1, 1'b1};
        vecs[2] = '{8'h00, 1'b1, -1, 0, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, -1, 0, 1'b0};
        vecs[4] = '{8'h80, 1'b1, -1, 2, 1'b0};
        vecs[5] = '{8'h01, 1'b1, -1, 0, 1'b0};
        vecs[6] = '{8'h00, 1'b1,  3, 0, 1'b0};
        vecs[7] = '{8'h3C, 1'b1,  5, 1, 1'b0};

        rst_n          = 1'b0;
        rx_pin8        = 1'b1;
        rx_pin7        = 1'b1;
        rx_data_ready8 = 1'b1;
        rx_data_ready7 = 1'b0;
        #1;
        checkOutput("rst_valid", int'(rx_data_valid8), 0);
        checkOutput("rst_data", int'(rx_data8), 0);
        checkOutput("rst_frame_err", int'(rx_frame_err8), 0);
        checkOutput("rst_parity_err", int'(rx_parity_err8), 0);
        checkOutput("rst_overrun", int'(rx_overrun8), 0);
        checkOutput("rst_state", int'(dut8.state), int'(S_IDLE));
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2 * CYC) @(posedge clk);
        #1;

        $display("[TB] table-driven frames on 8N1 receiver");
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back('{vecs[i].data, vecs[i].exp_fe, 1'b0});
            applyStimulus(1'b0, vecs[i].data, 8, 1'b0, 1'b0, vecs[i].stop_val,
                          vecs[i].glitch_bit, vecs[i].idle_bits);
        end
        wait_drain("table_drain");
        checkOutput("table_no_overrun", ovr_count, 0);

        $display("[TB] short low pulse on idle line");
        rx_pin8 = 1'b0;
        repeat (CYC / 4) @(posedge clk);
        #1 rx_pin8 = 1'b1;
        repeat (3 * CYC) @(posedge clk);
        #1;
        checkOutput("glitch_state", int'(dut8.state), int'(S_IDLE));
        checkOutput("glitch_valid", int'(rx_data_valid8), 0);

        $display("[TB] overrun with consumer stalled");
        rx_data_ready8 = 1'b0;
        ovr_count = 0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) sb_q.push_back('{8'(i), 1'b0, 1'b0});
            applyStimulus(1'b0, 8'(i), 8, 1'b0, 1'b0, 1'b1, -1, 0);
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("overrun_pulses", ovr_count, 1);
        checkOutput("overrun_head", int'(rx_data8), 1);
        checkOutput("overrun_valid", int'(rx_data_valid8), 1);
        rx_data_ready8 = 1'b1;
        wait_drain("overrun_drain");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("overrun_empty", int'(rx_data_valid8), 0);

        $display("[TB] 7E1 receiver parity checks");
        d7 = 7'h41;
        good_par = ^d7;
        applyStimulus(1'b1, {1'b0, d7}, 7, 1'b1, ~good_par, 1'b1, -1, 0);
        d7 = 7'h07;
        good_par = ^d7;
        applyStimulus(1'b1, {1'b0, d7}, 7, 1'b1, good_par, 1'b1, -1, 0);
        wait_valid7("par_valid1");
        checkOutput("par_data1", int'(rx_data7), 'h41);
        checkOutput("par_err1", int'(rx_parity_err7), 1);
        checkOutput("par_fe1", int'(rx_frame_err7), 0);
        @(posedge clk);
        #1 rx_data_ready7 = 1'b1;
        @(posedge clk);
        #1 rx_data_ready7 = 1'b0;
        checkOutput("par_valid2", int'(rx_data_valid7), 1);
        checkOutput("par_data2", int'(rx_data7), 'h07);
        checkOutput("par_err2", int'(rx_parity_err7), 0);
        rx_data_ready7 = 1'b1;
        @(posedge clk);
        #1 rx_data_ready7 = 1'b0;
        checkOutput("par_empty", int'(rx_data_valid7), 0);

        $display("[TB] reset during bit 3 of a frame");
        rx_data_ready8 = 1'b0;
        applyStimulus(1'b0, 8'h11, 8, 1'b0, 1'b0, 1'b1, -1, 0);
        checkOutput("pre_reset_valid", int'(rx_data_valid8), 1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        rx_pin8 = 1'b1;
        repeat (HALF_T) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", int'(rx_data_valid8), 0);
        checkOutput("midrst_data", int'(rx_data8), 0);
        checkOutput("midrst_state", int'(dut8.state), int'(S_IDLE));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rx_data_ready8 = 1'b1;
        repeat (2 * CYC) @(posedge clk);
        #1;
        checkOutput("postrst_valid", int'(rx_data_valid8), 0);
        sb_q.push_back('{8'h7E, 1'b0, 1'b0});
        applyStimulus(1'b0, 8'h7E, 8, 1'b0, 1'b0, 1'b1, -1, 1);
        wait_drain("postrst_drain");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("final_empty", int'(rx_data_valid8), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
